// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program store plus PC that issues held instruction words to the CPU
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   prog_we/addr/data - program store write port, honoured only when not running
//   start           - begin a run at address 0 (ignored while running or while writing)
//   instruction     - registered word to the CPU, NOP_WORD when nothing is issued
//   instr_valid     - instruction carries a program word
//   pc              - registered address of the word being issued
//   busy / done     - registered state decode (RUN / DONE)
module instr_sequencer #(
    parameter int                   INSTR_WIDTH = 20,
    parameter int                   PC_BITS     = 5,
    parameter int                   HOLD_CYCLES = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD  = 20'h00000,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = 20'hFFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 2 ** PC_BITS;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [PC_BITS-1:0] PC_LAST = PC_BITS'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [3:0]             hold_q, hold_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   mem_we;
    logic [PC_BITS-1:0]     pc_inc;
    logic [INSTR_WIDTH-1:0] next_word;
    logic [INSTR_WIDTH-1:0] first_word;

    // The store is frozen during a run, so the read path never sees a
    // same-cycle write to the word it is fetching.
    assign mem_we     = prog_we && (state_q != ST_RUN);
    assign pc_inc     = pc_q + PC_BITS'(1);
    assign next_word  = mem_q[pc_inc];
    assign first_word = mem_q[0];

    // Store is deliberately outside reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A simultaneous write wins over start.
                if (start && !prog_we) begin
                    pc_d   = '0;
                    hold_d = '0;
                    if (first_word == HALT_WORD) begin
                        state_d = ST_DONE;
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        instr_d = first_word;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end else if (pc_q == PC_LAST || next_word == HALT_WORD) begin
                    // pc keeps the last issued address; no wrap at end of store.
                    state_d = ST_DONE;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else begin
                    pc_d    = pc_inc;
                    instr_d = next_word;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                pc_d    = '0;
                hold_d  = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            pc_q    <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic        start = 1'b0;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [19:0] HALT = 20'hFFFFF;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_basic();
        write_word(5'd0, 20'h11111);
        write_word(5'd1, 20'h22222);
        write_word(5'd2, 20'h33333);
        write_word(5'd3, HALT);
    endtask

    task automatic run_to_done(input string name);
        int k;
        k = 0;
        while (!done && k < 200) begin
            step();
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: done=%b required 1", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({instruction, instr_valid, pc, busy, done} !== {20'h00000, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: instr=%h valid=%b pc=%0d busy=%b done=%b required 00000 0 0 0 0",
                     instruction, instr_valid, pc, busy, done);
        end
    endtask

    task automatic test_basic_run();
        logic [19:0] w [3];
        w[0] = 20'h11111;
        w[1] = 20'h22222;
        w[2] = 20'h33333;
        load_basic();
        pulse_start();
        for (int c = 0; c < 9; c++) begin
            n_cmp++;
            if ({busy, instr_valid, pc, instruction} !== {1'b1, 1'b1, 5'(c / 3), w[c / 3]}) begin
                n_err++;
                $display("FAIL basic_cycle%0d: busy=%b valid=%b pc=%0d instr=%h required 1 1 %0d %h",
                         c, busy, instr_valid, pc, instruction, c / 3, w[c / 3]);
            end
            step();
        end
        n_cmp++;
        if ({done, busy, instr_valid, pc, instruction} !== {1'b1, 1'b0, 1'b0, 5'd2, 20'h00000}) begin
            n_err++;
            $display("FAIL basic_done: done=%b busy=%b valid=%b pc=%0d instr=%h required 1 0 0 2 00000",
                     done, busy, instr_valid, pc, instruction);
        end
    endtask

    task automatic test_write_in_run();
        load_basic();
        pulse_start();
        repeat (3) step();
        n_cmp++;
        if (pc !== 5'd1) begin
            n_err++;
            $display("FAIL wr_run_pre_pc: pc=%0d required 1", pc);
        end
        write_word(5'd2, 20'h0ABCD);
        repeat (2) step();
        n_cmp++;
        if ({pc, instruction, instr_valid} !== {5'd2, 20'h33333, 1'b1}) begin
            n_err++;
            $display("FAIL wr_run_ignored: pc=%0d instr=%h valid=%b required 2 33333 1",
                     pc, instruction, instr_valid);
        end
        run_to_done("wr_run");
    endtask

    task automatic test_reset_midrun();
        pulse_start();
        repeat (4) step();
        n_cmp++;
        if ({pc, instruction} !== {5'd1, 20'h22222}) begin
            n_err++;
            $display("FAIL midrun_pre: pc=%0d instr=%h required 1 22222", pc, instruction);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, pc, instr_valid, instruction} !== {1'b0, 1'b0, 5'd0, 1'b0, 20'h00000}) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b pc=%0d valid=%b instr=%h required 0 0 0 0 00000",
                     busy, done, pc, instr_valid, instruction);
        end
        pulse_start();
        n_cmp++;
        if ({busy, instr_valid, pc, instruction} !== {1'b1, 1'b1, 5'd0, 20'h11111}) begin
            n_err++;
            $display("FAIL midrun_retained: busy=%b valid=%b pc=%0d instr=%h required 1 1 0 11111",
                     busy, instr_valid, pc, instruction);
        end
        run_to_done("midrun");
    endtask

    task automatic test_start_with_write();
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 20'h0BEEF;
        step();
        start   = 1'b0;
        prog_we = 1'b0;
        n_cmp++;
        if ({done, busy, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL start_we_stays_done: done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, instr_valid);
        end
        pulse_start();
        n_cmp++;
        if ({busy, instr_valid, pc, instruction} !== {1'b1, 1'b1, 5'd0, 20'h0BEEF}) begin
            n_err++;
            $display("FAIL start_we_written: busy=%b valid=%b pc=%0d instr=%h required 1 1 0 0beef",
                     busy, instr_valid, pc, instruction);
        end
        run_to_done("start_we");
    endtask

    task automatic test_full_store();
        for (int a = 0; a < 32; a++) begin
            write_word(5'(a), 20'h0000A + 20'(a));
        end
        pulse_start();
        for (int c = 0; c < 96; c++) begin
            n_cmp++;
            if ({busy, pc, instruction} !== {1'b1, 5'(c / 3), 20'h0000A + 20'(c / 3)}) begin
                n_err++;
                $display("FAIL full_cycle%0d: busy=%b pc=%0d instr=%h required 1 %0d %h",
                         c, busy, pc, instruction, c / 3, 20'h0000A + 20'(c / 3));
            end
            step();
        end
        n_cmp++;
        if ({done, busy, instr_valid, pc, instruction} !== {1'b1, 1'b0, 1'b0, 5'd31, 20'h00000}) begin
            n_err++;
            $display("FAIL full_done: done=%b busy=%b valid=%b pc=%0d instr=%h required 1 0 0 31 00000",
                     done, busy, instr_valid, pc, instruction);
        end
    endtask

    task automatic test_halt_first();
        write_word(5'd0, HALT);
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({done, busy, instr_valid, pc, instruction} !== {1'b1, 1'b0, 1'b0, 5'd0, 20'h00000}) begin
                n_err++;
                $display("FAIL halt_first_c%0d: done=%b busy=%b valid=%b pc=%0d instr=%h required 1 0 0 0 00000",
                         c, done, busy, instr_valid, pc, instruction);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_write_in_run();
        test_reset_midrun();
        test_start_with_write();
        test_full_store();
        test_halt_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
